// File: rtl/fetch_seq_pkg.sv
// -----------------------------------------------------------------------------
// fetch_seq_pkg
//   Shared definitions for the instruction fetch sequencer: the sequencer state
//   encoding, the HALT opcode, the default widths and a small opcode helper.
// -----------------------------------------------------------------------------
package fetch_seq_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    // Opcode lives in the top three bits of every instruction word.
    localparam logic [2:0] HALT_OP = 3'b111;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        ISSUE  = 3'd2,
        EXEC   = 3'd3,
        UPDATE = 3'd4,
        HALTED = 3'd5
    } state_e;

    function automatic logic is_halt(input logic [2:0] opcode);
        return opcode == HALT_OP;
    endfunction

endpackage : fetch_seq_pkg

// File: rtl/pc_counter.sv
// -----------------------------------------------------------------------------
// pc_counter
//   Program counter register. Load has priority over increment; the increment
//   wraps modulo 2^ADDR_W.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-low reset (pc -> RESET_PC)
//   load      in   synchronous load of load_val
//   load_val  in   value to load
//   inc       in   synchronous increment enable
//   pc        out  current program counter
// -----------------------------------------------------------------------------
module pc_counter #(
    parameter int                 ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            // Natural overflow of the ADDR_W-bit add gives the wrap to zero.
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule : pc_counter

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Top-level instruction sequencer. Fetches an instruction at PC through a
//   req/ack memory handshake, latches it in the IR, starts the execution FSM,
//   waits for it to finish and then advances the PC. Only HALT is decoded here.
//
// Ports:
//   clk, reset         clock; asynchronous active-low reset
//   run                level enable for fetching
//   pc_load/_val       load a new PC (only honoured in IDLE)
//   mem_addr, mem_rd   instruction read request (mem_addr always equals pc)
//   mem_rdata, mem_ack instruction data and single-cycle completion pulse
//   instr              instruction register contents
//   exec_start         one-cycle start pulse to the execution FSM
//   exec_idle          execution FSM is in its wait state
//   pc                 current program counter
//   halted, busy       status
//   retired            count of completed instructions (wraps at 16 bits)
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] instr,
    output logic              exec_start,
    input  logic              exec_idle,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              busy,
    output logic [15:0]       retired
);

    state_e            state_d,     state_q;
    logic [DATA_W-1:0] instr_d,     instr_q;
    logic [15:0]       retired_d,   retired_q;
    logic              seen_busy_d, seen_busy_q;

    logic              pc_load_en;
    logic              pc_inc;

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_load_en),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc)
    );

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        retired_d   = retired_q;
        seen_busy_d = seen_busy_q;
        pc_load_en  = 1'b0;
        pc_inc      = 1'b0;
        exec_start  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A load wins over run; fetching starts the cycle after.
                if (pc_load) begin
                    pc_load_en = 1'b1;
                end else if (run) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                if (mem_ack) begin
                    instr_d = mem_rdata;
                    state_d = is_halt(mem_rdata[DATA_W-1 -: 3]) ? HALTED : ISSUE;
                end
            end

            ISSUE: begin
                // The start pulse is qualified by exec_idle so the execution
                // FSM only ever sees it while it can accept it; the sequencer
                // leaves ISSUE on the same edge, making the pulse one cycle.
                if (exec_idle) begin
                    exec_start  = 1'b1;
                    seen_busy_d = 1'b0;
                    state_d     = EXEC;
                end
            end

            EXEC: begin
                // The execution FSM still reports idle in the cycle it takes
                // the start, so completion needs a busy phase seen first.
                if (!exec_idle) begin
                    seen_busy_d = 1'b1;
                end
                if (exec_idle && seen_busy_q) begin
                    state_d = UPDATE;
                end
            end

            UPDATE: begin
                pc_inc    = 1'b1;
                retired_d = retired_q + 16'd1;
                state_d   = run ? FETCH : IDLE;
            end

            HALTED: begin
                if (!run) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            retired_q   <= '0;
            seen_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            retired_q   <= retired_d;
            seen_busy_q <= seen_busy_d;
        end
    end

    assign mem_addr = pc;
    assign mem_rd   = (state_q == FETCH);
    assign halted   = (state_q == HALTED);
    assign busy     = (state_q != IDLE) && (state_q != HALTED);
    assign instr    = instr_q;
    assign retired  = retired_q;

endmodule : fetch_sequencer
